basys3_display_arbiter: RTL

// - Time-shares the single 16-bit BASYS3 seven-segment display word among NUM_REQ requesters
//   (core debug bus, switch mirror, register dump, ...) using round-robin with a minimum dwell time.
// - Sits between the requesters and the 7-seg driver's display input; all display sourcing goes through it.
// - Each requester holds a level request; the arbiter selects one owner, pulses its grant and shows its data.

---
 rtl/basys3_disp_pkg.sv | 12 +
 rtl/basys3_rr_pick.sv | 31 +++
 rtl/basys3_display_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/basys3_disp_pkg.sv
// Shared encodings and defaults for the seven-segment display arbiter.
package basys3_disp_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } disp_state_e;

  localparam int DISP_DATA_W       = 16;
  localparam int DISP_HOLD_DEFAULT = 100_000_000;

endpackage

// File: rtl/basys3_rr_pick.sv
// Round-robin picker: first asserted request at or after (ptr+1) mod NUM_REQ,
// so the requester at ptr itself is the last candidate.
module basys3_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int OWN_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWN_W-1:0]   ptr,
  output logic [OWN_W-1:0]   pick,
  output logic               any
);

  logic             found;
  logic [OWN_W-1:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = OWN_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/basys3_display_arbiter.sv
// Round-robin owner of the 7-seg display word with a minimum dwell per owner.
// Define DISP_ARB_LOCK_EN to add the lock input that freezes rotation in SHOW.
//
// state | meaning
// IDLE  | no owner being shown; display/owner hold last values
// SHOW  | owner's data on display; dwell counts down to the next arbitration
module basys3_display_arbiter
  import basys3_disp_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DISP_DATA_W,
  parameter int HOLD_CYCLES = DISP_HOLD_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef DISP_ARB_LOCK_EN
  input  logic                      lock,
`endif
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         display,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                      busy
);

  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int DWL_W = $clog2(HOLD_CYCLES);

  disp_state_e          state_q;
  logic [DWL_W-1:0]     dwell_q;
  logic [OWN_W-1:0]     ptr_q;
  logic [OWN_W-1:0]     owner_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [DATA_W-1:0]    display_q;
  logic                 busy_q;

  logic [OWN_W-1:0]     pick;
  logic                 any;
  logic [NUM_REQ-1:0]   gnt_d;
  logic [DATA_W-1:0]    pick_data;
  logic [DATA_W-1:0]    owner_data;
  logic                 lock_hold;

  basys3_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWN_W   (OWN_W)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

`ifdef DISP_ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    gnt_d       = '0;
    gnt_d[pick] = 1'b1;
  end

  assign pick_data  = req_data[int'(pick)*DATA_W +: DATA_W];
  assign owner_data = req_data[int'(owner_q)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dwell_q   <= '0;
      ptr_q     <= OWN_W'(NUM_REQ - 1);
      owner_q   <= '0;
      gnt_q     <= '0;
      display_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any) begin
            owner_q   <= pick;
            ptr_q     <= pick;
            gnt_q     <= gnt_d;
            display_q <= pick_data;
            dwell_q   <= DWL_W'(HOLD_CYCLES - 1);
            busy_q    <= 1'b1;
            state_q   <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (req[owner_q]) display_q <= owner_data;
          // A re-grant below overrides the tracking update with the new owner's word.
          if (!lock_hold) begin
            if (dwell_q != '0) begin
              dwell_q <= dwell_q - DWL_W'(1);
            end else if (any) begin
              owner_q   <= pick;
              ptr_q     <= pick;
              gnt_q     <= gnt_d;
              display_q <= pick_data;
              dwell_q   <= DWL_W'(HOLD_CYCLES - 1);
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign display = display_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule
